// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one single-word SDRAM controller port among four requesters.
// Optional done-watchdog is built in when ARB_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | no access in flight; arbitrate among iREQ bits
// ISSUE   | strobe and oSDR_* held for the granted port until iSDR_DONE
// RELEASE | access finished; wait for iSDR_DONE to fall before re-arbitrating
module sdram_rr_arbiter #(
  parameter int ASIZE   = 22,
  parameter int DSIZE   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic [3:0]         iREQ,
  input  logic [3:0]         iWR,
  input  logic [4*ASIZE-1:0] iADDR,
  input  logic [4*DSIZE-1:0] iDATA,
  output logic [3:0]         oACK,
  output logic [DSIZE-1:0]   oDATA,
  output logic [1:0]         oGNT_ID,
  output logic               oTIMEOUT,
  output logic [ASIZE-1:0]   oSDR_ADDR,
  output logic [DSIZE-1:0]   oSDR_DATA,
  output logic               oSDR_RD,
  output logic               oSDR_WR,
  input  logic [DSIZE-1:0]   iSDR_DATA,
  input  logic               iSDR_DONE
);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  state_t     state;
  logic [1:0] last;
  logic [1:0] win;

  // Walk from the farthest candidate to the nearest so the port right after
  // the last winner takes priority; the last winner itself ranks lowest.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] prev);
    logic [1:0] idx;
    rr_pick = prev;
    for (int k = 4; k >= 1; k--) begin
      idx = prev + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  assign win = rr_pick(iREQ, last);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt;
`else
  // The watchdog limit only matters when the watchdog is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign oTIMEOUT           = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state     <= IDLE;
      last      <= 2'd3;
      oACK      <= '0;
      oDATA     <= '0;
      oGNT_ID   <= '0;
      oSDR_ADDR <= '0;
      oSDR_DATA <= '0;
      oSDR_RD   <= 1'b0;
      oSDR_WR   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt       <= '0;
      oTIMEOUT  <= 1'b0;
`endif
    end else begin
      oACK <= '0;
`ifdef ARB_TIMEOUT_EN
      oTIMEOUT <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|iREQ) begin
            oSDR_WR   <= iWR[win];
            oSDR_RD   <= ~iWR[win];
            oSDR_ADDR <= iADDR[win*ASIZE +: ASIZE];
            oSDR_DATA <= iDATA[win*DSIZE +: DSIZE];
            oGNT_ID   <= win;
            last      <= win;
`ifdef ARB_TIMEOUT_EN
            cnt       <= '0;
`endif
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (iSDR_DONE) begin
            oSDR_RD <= 1'b0;
            oSDR_WR <= 1'b0;
            if (oSDR_RD) oDATA <= iSDR_DATA;
            oACK    <= 4'b0001 << oGNT_ID;
            state   <= RELEASE;
          end
`ifdef ARB_TIMEOUT_EN
          // cnt is 0 on the first ISSUE cycle, so TIMEOUT-1 marks the last allowed one.
          else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            oSDR_RD  <= 1'b0;
            oSDR_WR  <= 1'b0;
            oDATA    <= '0;
            oACK     <= 4'b0001 << oGNT_ID;
            oTIMEOUT <= 1'b1;
            state    <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          if (!iSDR_DONE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdram_rr_arbiter.md
# sdram_rr_arbiter

Round-robin arbiter that shares the single-word SDRAM controller port (address, read/write strobes, write data, read data, done) among four requesters. It replaces static select-line multiplexing: each requester raises a request, and the arbiter grants one at a time and sequences the strobe/done handshake with the controller. It returns read data and a one-cycle acknowledge to the winner. It sits between the host/async client ports and the SDRAM controller's host side.

## Interface
- ASIZE, 22, word address width toward the controller
- DSIZE, 16, data width
- TIMEOUT, 255, done-watchdog limit in cycles; used only with `ARB_TIMEOUT_EN`
- iCLK  in  1  system clock; all logic rising-edge
- iRST_n  in  1  asynchronous, active-low reset
- iREQ  in  4  per-port request; bit n = port n
- iWR  in  4  per-port direction: 1 = write, 0 = read
- iADDR  in  4*ASIZE  per-port address; port n at [n*ASIZE +: ASIZE]
- iDATA  in  4*DSIZE  per-port write data; port n at [n*DSIZE +: DSIZE]
- oACK  out  4  one-hot, one-cycle completion pulse
- oDATA  out  DSIZE  read data, valid in the oACK cycle, held until the next completion
- oGNT_ID  out  2  index of the current or last granted port
- oTIMEOUT  out  1  one-cycle pulse with oACK on watchdog abort
- oSDR_ADDR  out  ASIZE  address to the controller
- oSDR_DATA  out  DSIZE  write data to the controller
- oSDR_RD / oSDR_WR  out  1 each  controller strobes, mutually exclusive
- iSDR_DATA  in  DSIZE  controller read data
- iSDR_DONE  in  1  controller completion

## Operation
- FSM states: IDLE, ISSUE, RELEASE.
- IDLE: if any iREQ bit is set, pick a winner by round-robin.
  - Search order is L+1, L+2, L+3, L (mod 4), where L = last granted port.
  - Register the winner's iWR, iADDR and iDATA into oSDR_WR/oSDR_RD, oSDR_ADDR and oSDR_DATA.
  - Set L = winner and oGNT_ID = winner, then go to ISSUE.
- ISSUE: hold the strobe and all oSDR_* signals stable until iSDR_DONE is sampled high. Then:
  - Clear the strobe.
  - On a read, capture iSDR_DATA into oDATA. On a write, oDATA is unchanged.
  - Pulse oACK[winner].
  - Go to RELEASE.
- RELEASE: no arbitration. Stay while iSDR_DONE is high; go to IDLE on the first cycle it is low.
- Requester rules:
  - Hold iREQ, iWR, iADDR and iDATA stable until oACK is seen.
  - Inputs are sampled only at grant; later changes are ignored.
  - If iREQ is still high after oACK, it is treated as a new request.
- Fairness: with all four ports requesting continuously, grants rotate 0,1,2,3,0,...
- Reset values:
  - All outputs 0; oGNT_ID = 0.
  - L = 3, so port 0 wins the first arbitration.
  - State = IDLE.
- Reset mid-transaction: everything clears asynchronously, the in-flight access is dropped, and no oACK is issued.

## Timing
- Grant latency: a request visible in IDLE at edge k produces an oSDR_RD/WR strobe in cycle k+1.
- Completion: iSDR_DONE sampled high at edge m produces, in cycle m+1:
  - strobe low
  - oACK high
  - oDATA valid
- Minimum turnaround between back-to-back grants is ISSUE → RELEASE (≥1 cycle) → IDLE → next ISSUE:
  - The next strobe rises no earlier than cycle m+3.
  - A requester that drops iREQ on the edge after oACK is never re-granted.
- Exactly one oACK bit is high per completion; never two in the same cycle.
- Simultaneous iREQ assertion with RELEASE: the request waits; it is not lost.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit+ counter (sized to hold TIMEOUT) clears on entry to ISSUE and counts every ISSUE cycle.
  - If it reaches TIMEOUT with iSDR_DONE still low, the arbiter aborts: strobe low, oACK[winner] and oTIMEOUT pulse, oDATA = 0, next state RELEASE.
- `ARB_TIMEOUT_EN` undefined:
  - ISSUE waits indefinitely.
  - oTIMEOUT is tied to 0 and there is no counter logic.

## Test plan
- Single read: iREQ=4'b0100, iWR=0, iADDR[2]=22'h00_1234; the controller model returns 16'hBEEF with iSDR_DONE 5 cycles after the strobe → oSDR_RD high 1 cycle after the request, oSDR_ADDR=22'h00_1234, oACK=4'b0100 with oDATA=16'hBEEF, oGNT_ID=2.
- Single write: port 1 writes 16'hA5A5 to 22'h3F_FFFF → oSDR_WR high, oSDR_DATA=16'hA5A5 held until DONE, oACK=4'b0010, oDATA unchanged.
- Fairness: all four iREQ held high for 8 transactions → grant order 0,1,2,3,0,1,2,3; exactly one oACK per completion; strobe-to-strobe gap ≥3 cycles.
- Reset mid-access: assert iRST_n low while in ISSUE → oSDR_RD/WR, oACK and oDATA go to 0 immediately; after release, port 0 wins the next arbitration.
- Timeout (with `ARB_TIMEOUT_EN`, TIMEOUT=16): iSDR_DONE never asserted → strobe drops after 16 ISSUE cycles; oACK and oTIMEOUT pulse together; oDATA=0. Without the macro, the strobe stays high for 1000 cycles and oTIMEOUT stays 0.
- Held request after ACK: port 3 keeps iREQ high with port 0 also requesting → next grant goes to port 0 (round-robin), then port 3 again.
